// File: rtl/sysbus_arbiter.sv
// Round-robin arbiter that shares the single system bus between N_REQ masters,
// with registered one-hot grants, bus lock and a forced release after MAX_HOLD cycles.
module sysbus_arbiter #(
   parameter int N_REQ    = 3,
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 4,
   parameter int MAX_HOLD = 4
) (
   input  logic                      clock,
   input  logic                      n_reset,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ-1:0]          lock,
   input  logic [N_REQ*2-1:0]        req_dev,
   input  logic [N_REQ*ADDR_W-1:0]   req_opaddr,
   input  logic [N_REQ-1:0]          req_ldstr,
   input  logic [N_REQ*DATA_W-1:0]   req_wdata,
   output logic [N_REQ-1:0]          gnt,
   output logic [1:0]                bus_dev,
   output logic [ADDR_W-1:0]         bus_opaddr,
   output logic                      bus_ldstr,
   output logic [DATA_W-1:0]         bus_wdata,
   output logic                      bus_wen,
   input  logic [DATA_W-1:0]         bus_rdata,
   output logic [DATA_W-1:0]         rdata,
   output logic [N_REQ-1:0]          rvalid,
   output logic                      timeout
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int HW = $clog2(MAX_HOLD);

   typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;

   state_t            state_reg;
   logic [N_REQ-1:0]  gnt_reg;
   logic [N_REQ-1:0]  rvalid_reg;
   logic [PW-1:0]     ptr_reg;
   logic [HW-1:0]     hold_cnt_reg;
   logic [DATA_W-1:0] rdata_reg;
   logic              timeout_reg;

   // A master drives the bus only while it both owns the grant and still requests.
   logic [N_REQ-1:0]  sel;
   logic [1:0]        dev_g    [N_REQ];
   logic [ADDR_W-1:0] opaddr_g [N_REQ];
   logic [DATA_W-1:0] wdata_g  [N_REQ];

   assign sel = gnt_reg & req;

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_mst
         assign dev_g[gi]    = sel[gi] ? req_dev[gi*2 +: 2]              : 2'b00;
         assign opaddr_g[gi] = sel[gi] ? req_opaddr[gi*ADDR_W +: ADDR_W] : '0;
         assign wdata_g[gi]  = sel[gi] ? req_wdata[gi*DATA_W +: DATA_W]  : '0;
      end
   endgenerate

   always_comb begin
      bus_dev    = 2'b00;
      bus_opaddr = '0;
      bus_wdata  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         bus_dev    = bus_dev    | dev_g[i];
         bus_opaddr = bus_opaddr | opaddr_g[i];
         bus_wdata  = bus_wdata  | wdata_g[i];
      end
   end

   assign bus_ldstr = |(sel & req_ldstr);
   assign bus_wen   = bus_ldstr;

   logic own_req;
   logic own_lock;
   logic rd_hit;
   logic at_limit;
   logic extend;
   logic forced;
   logic [N_REQ-1:0] others;
   logic [N_REQ-1:0] arb_mask;

   assign own_req  = |sel;
   assign own_lock = |(sel & lock);
   assign rd_hit   = own_req & ~bus_ldstr & (bus_dev != 2'b00);
   assign at_limit = (hold_cnt_reg == HW'(MAX_HOLD - 1));
   assign extend   = (state_reg != IDLE) & own_req & own_lock & ~at_limit;
   assign forced   = (state_reg != IDLE) & own_req & own_lock & at_limit;
   assign others   = req & ~gnt_reg;
   // On forced release the owner sits out one decision unless nobody else wants the bus.
   assign arb_mask = (forced && (|others)) ? others : req;

   logic [PW-1:0]    win_idx;
   logic             win_found;
   logic [N_REQ-1:0] win_onehot;
   logic [PW-1:0]    ptr_next;
   int               scan_idx;

   always_comb begin
      win_idx   = '0;
      win_found = 1'b0;
      scan_idx  = 0;
      for (int i = 0; i < N_REQ; i++) begin
         scan_idx = int'(ptr_reg) + i;
         if (scan_idx >= N_REQ)
            scan_idx = scan_idx - N_REQ;
         if (!win_found && arb_mask[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = PW'(scan_idx);
         end
      end
   end

   assign win_onehot = N_REQ'(1) << win_idx;
   assign ptr_next   = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         state_reg    <= IDLE;
         gnt_reg      <= '0;
         ptr_reg      <= '0;
         hold_cnt_reg <= '0;
         rdata_reg    <= '0;
         rvalid_reg   <= '0;
         timeout_reg  <= 1'b0;
      end else begin
         rvalid_reg  <= '0;
         timeout_reg <= 1'b0;
         if (rd_hit) begin
            rdata_reg  <= bus_rdata;
            rvalid_reg <= gnt_reg;
         end
         case (state_reg)
            IDLE: begin
               hold_cnt_reg <= '0;
               if (win_found) begin
                  state_reg <= GRANT;
                  gnt_reg   <= win_onehot;
                  ptr_reg   <= ptr_next;
               end else begin
                  gnt_reg   <= '0;
               end
            end
            GRANT, LOCKED: begin
               if (extend) begin
                  state_reg    <= LOCKED;
                  hold_cnt_reg <= hold_cnt_reg + 1'b1;
               end else begin
                  timeout_reg  <= forced;
                  hold_cnt_reg <= '0;
                  if (win_found) begin
                     state_reg <= GRANT;
                     gnt_reg   <= win_onehot;
                     ptr_reg   <= ptr_next;
                  end else begin
                     state_reg <= IDLE;
                     gnt_reg   <= '0;
                  end
               end
            end
            default: begin
               state_reg    <= IDLE;
               gnt_reg      <= '0;
               hold_cnt_reg <= '0;
            end
         endcase
      end
   end

   assign gnt     = gnt_reg;
   assign rdata   = rdata_reg;
   assign rvalid  = rvalid_reg;
   assign timeout = timeout_reg;

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed bench for sysbus_arbiter: a vector table of per-cycle stimulus and
// expected outputs, plus hand-written sequences for mid-cycle drop and reset.
module tb_sysbus_arbiter;

   logic        clock = 1'b0;
   logic        n_reset = 1'b0;
   logic [2:0]  req = '0;
   logic [2:0]  lock = '0;
   logic [5:0]  req_dev = '0;
   logic [11:0] req_opaddr = '0;
   logic [2:0]  req_ldstr = '0;
   logic [47:0] req_wdata = '0;
   logic [15:0] bus_rdata = '0;
   logic [2:0]  gnt;
   logic [1:0]  bus_dev;
   logic [3:0]  bus_opaddr;
   logic        bus_ldstr;
   logic [15:0] bus_wdata;
   logic        bus_wen;
   logic [15:0] rdata;
   logic [2:0]  rvalid;
   logic        timeout;

   int n_chk = 0;
   int n_fail = 0;

   sysbus_arbiter #(.N_REQ(3), .DATA_W(16), .ADDR_W(4), .MAX_HOLD(4)) dut (
      .clock      (clock),
      .n_reset    (n_reset),
      .req        (req),
      .lock       (lock),
      .req_dev    (req_dev),
      .req_opaddr (req_opaddr),
      .req_ldstr  (req_ldstr),
      .req_wdata  (req_wdata),
      .gnt        (gnt),
      .bus_dev    (bus_dev),
      .bus_opaddr (bus_opaddr),
      .bus_ldstr  (bus_ldstr),
      .bus_wdata  (bus_wdata),
      .bus_wen    (bus_wen),
      .bus_rdata  (bus_rdata),
      .rdata      (rdata),
      .rvalid     (rvalid),
      .timeout    (timeout)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic        rst;
      logic [2:0]  req;
      logic [2:0]  lock;
      logic [2:0]  ldstr;
      logic [5:0]  dev;
      logic [11:0] opaddr;
      logic [47:0] wdata;
      logic [15:0] brd;
      logic [2:0]  e_gnt;
      logic [1:0]  e_bdev;
      logic [3:0]  e_bop;
      logic        e_bld;
      logic [15:0] e_bwd;
      logic        e_bwen;
      logic [15:0] e_rdata;
      logic [2:0]  e_rvalid;
      logic        e_tmo;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input logic rst, input logic [2:0] rq, input logic [2:0] lk,
                          input logic [2:0] ls, input logic [5:0] dv, input logic [11:0] op,
                          input logic [47:0] wd, input logic [15:0] brd,
                          input logic [2:0] eg, input logic [1:0] edv, input logic [3:0] eop,
                          input logic eld, input logic [15:0] ewd, input logic ewen,
                          input logic [15:0] erd, input logic [2:0] erv, input logic etm);
      vec_t v;
      v.rst = rst; v.req = rq; v.lock = lk; v.ldstr = ls; v.dev = dv; v.opaddr = op;
      v.wdata = wd; v.brd = brd; v.e_gnt = eg; v.e_bdev = edv; v.e_bop = eop;
      v.e_bld = eld; v.e_bwd = ewd; v.e_bwen = ewen; v.e_rdata = erd;
      v.e_rvalid = erv; v.e_tmo = etm;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pulse_reset();
      n_reset = 1'b0;
      #1;
      n_reset = 1'b1;
   endtask

   initial begin
      // single ROM read by master 0
      add_vec(1, 3'b001, 0, 0, 6'h01, 12'h005, 48'h0, 16'hBEEF, 3'b000, 2'b00, 4'h0, 0, 16'h0,    0, 16'h0,    3'b000, 0);
      add_vec(0, 3'b001, 0, 0, 6'h01, 12'h005, 48'h0, 16'hBEEF, 3'b001, 2'b01, 4'h5, 0, 16'h0,    0, 16'h0,    3'b000, 0);
      add_vec(0, 3'b000, 0, 0, 6'h01, 12'h005, 48'h0, 16'hBEEF, 3'b001, 2'b00, 4'h0, 0, 16'h0,    0, 16'hBEEF, 3'b001, 0);
      add_vec(0, 3'b000, 0, 0, 6'h01, 12'h005, 48'h0, 16'hBEEF, 3'b000, 2'b00, 4'h0, 0, 16'h0,    0, 16'hBEEF, 3'b000, 0);
      // all masters requesting, no lock: rotation without gaps
      add_vec(1, 3'b111, 0, 0, 6'h15, 12'hCBA, 48'h3333_2222_1111, 16'h1000, 3'b000, 2'b00, 4'h0, 0, 16'h0,    0, 16'h0,    3'b000, 0);
      add_vec(0, 3'b111, 0, 0, 6'h15, 12'hCBA, 48'h3333_2222_1111, 16'h1001, 3'b001, 2'b01, 4'hA, 0, 16'h1111, 0, 16'h0,    3'b000, 0);
      add_vec(0, 3'b111, 0, 0, 6'h15, 12'hCBA, 48'h3333_2222_1111, 16'h1002, 3'b010, 2'b01, 4'hB, 0, 16'h2222, 0, 16'h1001, 3'b001, 0);
      add_vec(0, 3'b111, 0, 0, 6'h15, 12'hCBA, 48'h3333_2222_1111, 16'h1003, 3'b100, 2'b01, 4'hC, 0, 16'h3333, 0, 16'h1002, 3'b010, 0);
      add_vec(0, 3'b111, 0, 0, 6'h15, 12'hCBA, 48'h3333_2222_1111, 16'h1004, 3'b001, 2'b01, 4'hA, 0, 16'h1111, 0, 16'h1003, 3'b100, 0);
      // master 1 locks against competitors until forced release
      add_vec(1, 3'b010, 3'b010, 0, 6'h00, 12'hCBA, 48'h0, 16'h0, 3'b000, 2'b00, 4'h0, 0, 16'h0, 0, 16'h0, 3'b000, 0);
      add_vec(0, 3'b111, 3'b010, 0, 6'h00, 12'hCBA, 48'h0, 16'h0, 3'b010, 2'b00, 4'hB, 0, 16'h0, 0, 16'h0, 3'b000, 0);
      add_vec(0, 3'b111, 3'b010, 0, 6'h00, 12'hCBA, 48'h0, 16'h0, 3'b010, 2'b00, 4'hB, 0, 16'h0, 0, 16'h0, 3'b000, 0);
      add_vec(0, 3'b111, 3'b010, 0, 6'h00, 12'hCBA, 48'h0, 16'h0, 3'b010, 2'b00, 4'hB, 0, 16'h0, 0, 16'h0, 3'b000, 0);
      add_vec(0, 3'b111, 3'b010, 0, 6'h00, 12'hCBA, 48'h0, 16'h0, 3'b010, 2'b00, 4'hB, 0, 16'h0, 0, 16'h0, 3'b000, 0);
      add_vec(0, 3'b111, 3'b010, 0, 6'h00, 12'hCBA, 48'h0, 16'h0, 3'b100, 2'b00, 4'hC, 0, 16'h0, 0, 16'h0, 3'b000, 1);
      add_vec(0, 3'b111, 3'b010, 0, 6'h00, 12'hCBA, 48'h0, 16'h0, 3'b001, 2'b00, 4'hA, 0, 16'h0, 0, 16'h0, 3'b000, 0);
      // master 2 store to RAM
      add_vec(1, 3'b100, 0, 3'b100, 6'h20, 12'h300, 48'h1234_0000_0000, 16'hFFFF, 3'b000, 2'b00, 4'h0, 0, 16'h0,    0, 16'h0, 3'b000, 0);
      add_vec(0, 3'b100, 0, 3'b100, 6'h20, 12'h300, 48'h1234_0000_0000, 16'hFFFF, 3'b100, 2'b10, 4'h3, 1, 16'h1234, 1, 16'h0, 3'b000, 0);
      add_vec(0, 3'b000, 0, 3'b100, 6'h20, 12'h300, 48'h1234_0000_0000, 16'hFFFF, 3'b100, 2'b00, 4'h0, 0, 16'h0,    0, 16'h0, 3'b000, 0);
      add_vec(0, 3'b000, 0, 3'b100, 6'h20, 12'h300, 48'h1234_0000_0000, 16'hFFFF, 3'b000, 2'b00, 4'h0, 0, 16'h0,    0, 16'h0, 3'b000, 0);

      #2;
      n_reset = 1'b1;

      foreach (vecs[k]) begin
         vec_t v;
         v = vecs[k];
         @(posedge clock);
         #1;
         req = v.req; lock = v.lock; req_ldstr = v.ldstr; req_dev = v.dev;
         req_opaddr = v.opaddr; req_wdata = v.wdata; bus_rdata = v.brd;
         if (v.rst)
            pulse_reset();
         #1;
         chk($sformatf("v%0d.gnt", k),        gnt,        v.e_gnt);
         chk($sformatf("v%0d.bus_dev", k),    bus_dev,    v.e_bdev);
         chk($sformatf("v%0d.bus_opaddr", k), bus_opaddr, v.e_bop);
         chk($sformatf("v%0d.bus_ldstr", k),  bus_ldstr,  v.e_bld);
         chk($sformatf("v%0d.bus_wdata", k),  bus_wdata,  v.e_bwd);
         chk($sformatf("v%0d.bus_wen", k),    bus_wen,    v.e_bwen);
         chk($sformatf("v%0d.rdata", k),      rdata,      v.e_rdata);
         chk($sformatf("v%0d.rvalid", k),     rvalid,     v.e_rvalid);
         chk($sformatf("v%0d.timeout", k),    timeout,    v.e_tmo);
         $display("vec %0d: req=%b lock=%b gnt=%b bus_dev=%b op=%h wen=%b rdata=%h rvalid=%b timeout=%b",
                  k, v.req, v.lock, gnt, bus_dev, bus_opaddr, bus_wen, rdata, rvalid, timeout);
      end

      // master 0 storing drops req mid-cycle while master 1 starts requesting
      @(posedge clock);
      #1;
      lock = 3'b000; req = 3'b001; req_ldstr = 3'b001; req_dev = 6'h06;
      req_opaddr = 12'h0B7; req_wdata = 48'h0000_5555_AAAA;
      pulse_reset();
      @(posedge clock);
      #2;
      chk("drop.gnt_before", gnt, 3'b001);
      chk("drop.wen_before", bus_wen, 1'b1);
      chk("drop.dev_before", bus_dev, 2'b10);
      req = 3'b010;
      #1;
      chk("drop.dev_same_cycle", bus_dev, 2'b00);
      chk("drop.wen_same_cycle", bus_wen, 1'b0);
      chk("drop.wdata_same_cycle", bus_wdata, 16'h0);
      chk("drop.gnt_held", gnt, 3'b001);
      @(posedge clock);
      #1;
      chk("drop.gnt_next", gnt, 3'b010);
      chk("drop.dev_next", bus_dev, 2'b01);
      chk("drop.op_next", bus_opaddr, 4'hB);
      $display("drop seq: gnt=%b bus_dev=%b op=%h wen=%b", gnt, bus_dev, bus_opaddr, bus_wen);

      // reset asserted while master 0 holds the bus locked
      @(posedge clock);
      #1;
      req = 3'b011; lock = 3'b001; req_ldstr = 3'b000; req_dev = 6'h05;
      req_opaddr = 12'h0BA; bus_rdata = 16'h5A5A;
      pulse_reset();
      @(posedge clock);
      #1;
      chk("rst.gnt_first", gnt, 3'b001);
      @(posedge clock);
      #1;
      chk("rst.gnt_locked", gnt, 3'b001);
      chk("rst.rvalid_locked", rvalid, 3'b001);
      chk("rst.rdata_locked", rdata, 16'h5A5A);
      #2;
      n_reset = 1'b0;
      #1;
      chk("rst.gnt_cleared", gnt, 3'b000);
      chk("rst.bus_dev_cleared", bus_dev, 2'b00);
      chk("rst.bus_op_cleared", bus_opaddr, 4'h0);
      chk("rst.rvalid_cleared", rvalid, 3'b000);
      chk("rst.timeout_cleared", timeout, 1'b0);
      chk("rst.rdata_cleared", rdata, 16'h0);
      n_reset = 1'b1;
      req = 3'b111; lock = 3'b000;
      @(posedge clock);
      #1;
      chk("rst.ptr0_wins", gnt, 3'b001);
      @(posedge clock);
      #1;
      chk("rst.then_port1", gnt, 3'b010);
      chk("rst.no_timeout", timeout, 1'b0);
      $display("reset seq: gnt=%b rvalid=%b timeout=%b", gnt, rvalid, timeout);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sysbus_arbiter.md
Name: sysbus_arbiter

Overview:
- Shares the single system bus (device select, opaddr, load/store strobe, data) between up to N_REQ masters.
- Masters are: sequencer instruction fetch (port 0), sequencer data/ALU access (port 1), debug/DMA loader (port 2).
- Grants use round-robin priority. Grants are registered, and a master may hold the bus with a lock for multi-cycle transactions.
- A hold timeout prevents a master from starving the others. The block sits between the masters and the ROM/RAM/ALU devices.

Parameters:
- N_REQ, 3, number of requesting masters (2..8).
- DATA_W, 16, system bus data width.
- ADDR_W, 4, opaddr width.
- MAX_HOLD, 4, maximum consecutive grant cycles per master before forced release (>=2).

Ports:
- clock  in  1  system clock, all state on rising edge
- n_reset  in  1  asynchronous active-low reset
- req  in  N_REQ  per-master bus request, level
- lock  in  N_REQ  per-master "keep bus next cycle" qualifier
- req_dev  in  N_REQ*2  per-master device select (00 none, ROM, RAM, ALU codes)
- req_opaddr  in  N_REQ*ADDR_W  per-master address/ALU opcode
- req_ldstr  in  N_REQ  per-master strobe, 1 = store
- req_wdata  in  N_REQ*DATA_W  per-master write data
- gnt  out  N_REQ  registered one-hot grant
- bus_dev  out  2  device select to bus
- bus_opaddr  out  ADDR_W  address/opcode to bus
- bus_ldstr  out  1  store strobe to bus
- bus_wdata  out  DATA_W  write data to bus
- bus_wen  out  1  data driver enable (tristate control)
- bus_rdata  in  DATA_W  data returned by device
- rdata  out  DATA_W  registered read data
- rvalid  out  N_REQ  one-cycle read-complete pulse per master
- timeout  out  1  one-cycle pulse on forced release

Behaviour:
- Reset (asynchronous, any state): state=IDLE, gnt=0, ptr=0, hold_cnt=0, rdata=0, rvalid=0, timeout=0. All bus_* outputs are 0.
- States: IDLE, GRANT, LOCKED.
- Arbitration: the winner is the first asserted req scanning from ptr upward, modulo N_REQ. On each new grant, ptr <= winner+1 (wraps at N_REQ).
- Latency: req sampled at edge k gives gnt at cycle k+1. Only one gnt bit is ever set.
- IDLE: gnt=0. If any req is set, go to GRANT with the winner; otherwise stay in IDLE.
- GRANT or LOCKED with master w granted:
  - bus_* = master w's inputs only while req[w]=1; otherwise all bus_* = 0.
  - bus_wen = req[w] & req_ldstr[w].
- End of each granted cycle:
  - If req[w] & ~req_ldstr[w] & req_dev[w]!=00: rdata <= bus_rdata and rvalid[w] pulses next cycle.
  - If req[w] & lock[w] & hold_cnt < MAX_HOLD-1: go to LOCKED, hold_cnt++, keep w.
  - Else if req[w] & lock[w] & hold_cnt == MAX_HOLD-1: forced release. timeout pulses next cycle, then rearbitrate over req excluding w for that one decision. If no other req is set, regrant w.
  - Else: rearbitrate. Back-to-back grants happen with no idle bubble. If no req is set, go to IDLE with gnt=0 next cycle.
  - hold_cnt clears on every new grant and in IDLE.
- Master w dropping req while granted: bus_* go to 0 in the same cycle (combinational gate). gnt is removed at the next edge.
- A request asserted by the current owner after release is arbitrated normally. The owner is lowest priority because of the ptr rotation.
- Store: single cycle. A store followed by a dependent read uses lock.
- Simultaneous requests from all masters at reset: port 0 wins, then 1, then 2.
- Reset asserted mid-LOCKED: the bus is released immediately with no rvalid and no timeout.

Test Plan:
- Reset, then req=001, dev=ROM, opaddr=5, ldstr=0, bus_rdata=0xBEEF. Expect: gnt=001 one cycle later, bus_dev=ROM, bus_opaddr=5; next cycle rdata=0xBEEF, rvalid=001; then IDLE.
- req=111 held constantly, no lock. Expect: gnt sequence 001,010,100,001 with no gaps.
- Master 1 with req=1, lock=1, others requesting, MAX_HOLD=4. Expect: gnt=010 for exactly 4 cycles, timeout pulse, then gnt=100.
- Master 2 store: dev=RAM, opaddr=3, wdata=0x1234, ldstr=1. Expect: bus_wen=1, bus_ldstr=1, bus_wdata=0x1234 during grant; no rvalid.
- While granted, master 0 drops req mid-cycle. Expect: bus_dev=0 and bus_wen=0 in the same cycle; gnt=0 or the next winner at the following edge.
- n_reset pulsed low during LOCKED. Expect: gnt, bus_*, rvalid and timeout all 0 immediately; ptr=0 afterward, so port 0 wins the next tie.
